// File: rtl/bus_fifo_buffer.sv
// Buffered tristate bus driver: queues producer words and drives the oldest
// word onto the shared bus while enabled; the consumer pops explicitly.
module bus_fifo_buffer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] in,
  input  logic             pop,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic             overflow
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic             pop_ok_c;
  logic             push_ok_c;
  logic [CW-1:0]    count_next_c;

  // Accept decisions; a same-cycle pop frees the slot a full-queue push needs.
  always_comb begin
    pop_ok_c     = pop && !empty;
    push_ok_c    = load && (!full || pop_ok_c);
    count_next_c = count;
    if (push_ok_c && !pop_ok_c) begin
      count_next_c = count + CW'(1);
    end else if (pop_ok_c && !push_ok_c) begin
      count_next_c = count - CW'(1);
    end
  end

  // Pointers, occupancy flags and sticky overflow; reset wins over load/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (pop_ok_c) begin
        head <= head + PW'(1);
      end
      if (push_ok_c) begin
        tail <= tail + PW'(1);
      end
      if (load && !push_ok_c) begin
        overflow <= 1'b1;
      end
      count <= count_next_c;
      full  <= (count_next_c == CW'(DEPTH));
      empty <= (count_next_c == '0);
    end
  end

  // Storage is deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (!rst && push_ok_c) begin
      mem[tail] <= in;
    end
  end

  // Bus driver releases the bus whenever disabled or nothing is queued.
  assign out = (en && !empty) ? mem[head] : {WIDTH{1'bz}};

endmodule

// File: tb/tb_bus_fifo_buffer.sv
// Directed bench for bus_fifo_buffer (WIDTH=8, DEPTH=4).
module tb_bus_fifo_buffer;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 3;

  logic             clk;
  logic             rst;
  logic             load;
  logic [WIDTH-1:0] in_d;
  logic             pop;
  logic             en;
  wire  [WIDTH-1:0] out_bus;
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;
  logic             overflow;

  int n_cmp;
  int n_bad;

  logic [WIDTH-1:0] zz;
  logic [WIDTH-1:0] model_q [$];

  bus_fifo_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .in       (in_d),
    .pop      (pop),
    .en       (en),
    .out      (out_bus),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock with the given request; requests drop after the edge.
  task automatic tick(input logic l, input logic [WIDTH-1:0] d, input logic p);
    load = l;
    in_d = d;
    pop  = p;
    @(posedge clk);
    #1;
    load = 1'b0;
    pop  = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] fill [4];
    logic [WIDTH-1:0] exp_out;
    logic             r_load;
    logic             r_pop;
    logic [WIDTH-1:0] r_data;
    logic             m_pop;
    logic             m_push;

    n_cmp = 0;
    n_bad = 0;
    zz    = {WIDTH{1'bz}};
    fill[0] = 8'hAA; fill[1] = 8'h55; fill[2] = 8'h04; fill[3] = 8'hFF;

    rst = 1'b1; load = 1'b0; pop = 1'b0; in_d = '0; en = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    tick(1'b0, 8'h00, 1'b0);
    check("rst_out",      32'(out_bus),  32'(zz));
    check("rst_empty",    32'(empty),    32'd1);
    check("rst_full",     32'(full),     32'd0);
    check("rst_count",    32'(count),    32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);

    // Single word, enable toggling
    en = 1'b0;
    tick(1'b1, 8'hAA, 1'b0);
    check("one_out_en0", 32'(out_bus), 32'(zz));
    check("one_count",   32'(count),   32'd1);
    en = 1'b1; #1;
    check("one_out_en1", 32'(out_bus), 32'hAA);
    en = 1'b0; #1;
    check("one_out_drop", 32'(out_bus), 32'(zz));
    tick(1'b0, 8'h00, 1'b1);
    en = 1'b1; #1;
    check("one_pop_empty", 32'(empty),   32'd1);
    check("one_pop_out",   32'(out_bus), 32'(zz));

    // Fill, overflow, drain
    for (int i = 0; i < 4; i++) tick(1'b1, fill[i], 1'b0);
    check("fill_full",  32'(full),  32'd1);
    check("fill_count", 32'(count), 32'd4);
    tick(1'b1, 8'h11, 1'b0);
    check("ovf_count", 32'(count),    32'd4);
    check("ovf_flag",  32'(overflow), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_out%0d", i), 32'(out_bus), 32'(fill[i]));
      tick(1'b0, 8'h00, 1'b1);
    end
    check("drain_out_z",  32'(out_bus), 32'(zz));
    check("drain_empty",  32'(empty),   32'd1);
    check("ovf_sticky",   32'(overflow), 32'd1);

    // Full queue: push and pop together
    for (int i = 0; i < 4; i++) tick(1'b1, fill[i], 1'b0);
    tick(1'b1, 8'h22, 1'b1);
    check("fpp_count",    32'(count),    32'd4);
    check("fpp_head",     32'(out_bus),  32'h55);
    check("fpp_overflow", 32'(overflow), 32'd1);
    for (int i = 0; i < 3; i++) tick(1'b0, 8'h00, 1'b1);
    check("fpp_last",  32'(out_bus), 32'h22);
    check("fpp_cnt1",  32'(count),   32'd1);
    tick(1'b0, 8'h00, 1'b1);
    check("fpp_empty", 32'(empty), 32'd1);

    // Empty queue: push and pop together, then pop on empty
    tick(1'b1, 8'h33, 1'b1);
    check("epp_count", 32'(count),   32'd1);
    check("epp_out",   32'(out_bus), 32'h33);
    tick(1'b0, 8'h00, 1'b1);
    check("epp_pop_count", 32'(count), 32'd0);
    tick(1'b0, 8'h00, 1'b1);
    check("under_count", 32'(count), 32'd0);
    check("under_empty", 32'(empty), 32'd1);
    check("under_full",  32'(full),  32'd0);

    // Pointer wrap against a reference queue
    model_q.delete();
    for (int i = 0; i < 10; i++) begin
      r_load = ($urandom_range(0, 3) != 0);
      r_pop  = ($urandom_range(0, 2) == 0);
      r_data = WIDTH'($urandom_range(1, 255));
      m_pop  = r_pop && (model_q.size() > 0);
      m_push = r_load && ((model_q.size() < DEPTH) || m_pop);
      if (m_pop)  void'(model_q.pop_front());
      if (m_push) model_q.push_back(r_data);
      tick(r_load, r_data, r_pop);
      exp_out = (model_q.size() > 0) ? model_q[0] : zz;
      check($sformatf("wrap_out%0d", i),   32'(out_bus), 32'(exp_out));
      check($sformatf("wrap_count%0d", i), 32'(count),   32'(model_q.size()));
    end

    // Reset mid-stream with a push pending
    tick(1'b1, 8'h66, 1'b0);
    rst = 1'b1;
    tick(1'b1, 8'h77, 1'b0);
    rst = 1'b0;
    check("mrst_count",    32'(count),    32'd0);
    check("mrst_overflow", 32'(overflow), 32'd0);
    check("mrst_out",      32'(out_bus),  32'(zz));
    check("mrst_empty",    32'(empty),    32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_fifo_buffer.md
Name: bus_fifo_buffer

Overview:
Parametrised, buffered successor to the plain tristate bus buffer. Queues up to DEPTH words from a producer and drives the oldest word onto the shared CPU data bus through a tristate output while the enable is high. The consumer pops words explicitly, so the buffer decouples bus timing from producer timing. Sits between peripheral/ALU result sources and the shared bus.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 4, number of storage entries; power of two, >=2
CW, $clog2(DEPTH+1), width of the count output (derived; not overridden)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset, sampled on rising edge of clk
load  input  1  push request: write in into tail entry
in  input  WIDTH  data to push
pop  input  1  pop request: discard head entry
en  input  1  output enable for the bus driver
out  output  WIDTH  tristate bus output
full  output  1  high when count == DEPTH
empty  output  1  high when count == 0
count  output  CW  number of valid entries
overflow  output  1  sticky: a push was rejected

Behaviour:
- Reset (rst=1 at rising edge): head ptr=0, tail ptr=0, count=0, overflow=0. Resulting outputs: empty=1, full=0. Storage contents are not cleared. rst has priority over load and pop in the same cycle. Reset mid-stream discards all queued data.
- out is combinational and not registered:
  - en=1 and empty=0: out = head entry.
  - otherwise: out = all-Z ({WIDTH{1'bz}}).
  - Never drives while empty. en has no effect on state.
- Push accepted when load=1 and (full=0, or pop is accepted in the same cycle). An accepted push writes in to mem[tail], then tail advances.
- Pop accepted when pop=1 and empty=0. An accepted pop advances head. A pop while empty is ignored silently.
- Simultaneous accepted push and pop: count unchanged, both pointers advance.
  - Full + load + pop: the push is accepted.
  - Empty + load + pop: only the push is accepted; count becomes 1.
- Rejected push (load=1, full=1, no accepted pop): data is dropped and overflow is set to 1. overflow stays 1 until rst.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH naturally. count updates by +1, -1 or 0.
- Latency:
  - A word pushed at edge N is visible on out (if en=1) after edge N when the queue was empty.
  - Otherwise it appears after all earlier words have been popped.
  - Pop takes effect at the edge; out shows the next head combinationally after that edge.
- full, empty and count are derived from registered count. They reflect state after the most recent edge.
- No X on full, empty, count or overflow at any time after the first reset.

Test Plan:
- Reset then idle, en=1 -> out=ZZ, empty=1, full=0, count=0, overflow=0.
- Push 8'hAA, en=0 -> out=ZZ, count=1. Raise en -> out=AA. Drop en -> out=ZZ. Pop -> empty=1, out stays ZZ even with en=1.
- Push AA, 55, 04, FF (DEPTH=4) -> full=1, count=4. Push 11 -> count=4 and overflow=1. Pop four times with en=1 -> out sequence AA, 55, 04, FF, then ZZ. 11 never appears.
- Full queue, load=1 with 22 and pop=1 in the same cycle -> count stays 4, head becomes 55, overflow unchanged. After 3 more pops out=22.
- Empty queue, load=1 with 33 and pop=1 together -> count=1, out=33 (en=1). Then pop only on empty -> count stays 0, no underflow.
- Pointer wrap: 10 push/pop cycles with random data against a reference queue -> out always equals the model head. Assert rst mid-stream with load=1 -> count=0, overflow=0, out=ZZ next cycle.
